seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Holds a 16-bit hex value and per-digit decimal points, and cycles one digit per scan slot through a single shared HEX7SEG decoder.
- Drives registered active-low anode and segment lines, with a ghost-suppression blank gap between slots.
- Accepts new display data through a write/ack handshake and commits it only at a frame boundary, so a frame never tears.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 4..65535.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off; must be < CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe, one cycle; latches wr_data/wr_dp
- wr_data  in  16  four hex nibbles; [3:0] = digit 0 (rightmost)
- wr_dp  in  4  decimal point per digit, 1 = lit; bit i = digit i
- lz_en  in  1  leading-zero blanking enable (level, sampled every cycle)
- upd_ack  out  1  one-cycle pulse when written data becomes the displayed data
- pending  out  1  written data waiting for the frame boundary
- an_n  out  4  digit anodes, active-low; bit i = digit i
- seg_n  out  8  segments, active-low; bit order 7=dp, 6=g … 0=a

Behaviour:
- Reset (async, immediate): an_n=4'hF, seg_n=8'hFF, upd_ack=0, pending=0, prescaler=0, digit_sel=0, shadow value/dp=0, pending registers=0.
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps;
  - slot_tick is asserted when the count equals CLK_DIV-1;
  - on slot_tick, digit_sel advances 0→1→2→3→0.
- Frame boundary = slot_tick while digit_sel==3.
- Write handshake:
  - wr_en loads the pending registers and sets pending=1;
  - a later wr_en before commit overwrites them (last write wins, no ack for the overwritten data).
- Commit:
  - at a frame boundary with pending=1, the shadow registers take the pending registers, pending→0, and upd_ack=1 for that cycle only;
  - if wr_en coincides with the frame boundary, the incoming wr_data/wr_dp are committed directly, pending→0, and upd_ack=1.
- Commit visibility: committed data is first displayed in the digit-0 slot that begins on the next cycle.
- Digit selection: nibble = shadow[4*digit_sel+3 : 4*digit_sel] drives the HEX7SEG value input.
- seg_n (registered): seg_n = ~{shadow_dp[digit_sel], code[6:0]}. The decoder's bit 7 is ignored.
- an_n (registered): bit digit_sel is 0 when (prescaler ≥ BLANK_CYC) and the digit is not blanked; all other bits are 1.
- Leading-zero blanking (lz_en=1):
  - digit k (k=3..1) is blanked when nibbles k..3 are all zero and the digit's dp is 0;
  - digit 0 is never blanked.
- Latency: an_n/seg_n reflect the prescaler/digit_sel state one cycle later (single output register stage).
- Blank gap: each slot shows BLANK_CYC cycles of an_n=4'hF, then CLK_DIV-BLANK_CYC cycles with one anode low.
- Reset mid-frame: all state is cleared and scanning restarts at digit 0 with a blank gap; a pending write is discarded with no ack.
- Width rules: digit_sel is 2 bits with natural wrap; the prescaler is 16 bits.

Decomposition:
- Shared package/header: segment bit-index constants (SEG_A..SEG_G, SEG_DP), NUM_DIGITS=4, and the ANODE_OFF=4'hF / SEG_OFF=8'hFF constants.
- One sub-module: a single instance of the existing HEX7SEG decoder (combinational, shared across all digits).
- Prescaler, scan counter, handshake and output registers live in seg7_scan_ctrl itself.

Test Plan:
- Reset scan (CLK_DIV=4, BLANK_CYC=1, no writes): after rst release, an_n cycles F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7; seg_n=8'hC0 ("0") whenever an anode is low.
- Write 16'h12AF, wr_dp=4'b0010, mid-frame:
  - pending=1 until the digit-3→0 boundary, then upd_ack pulses once;
  - in the next frame seg_n reads digit0=8'h8E, digit1=8'h08 (A + dp), digit2=8'hA4, digit3=8'hF9.
- Two writes (16'h1111 then 16'h2222) inside one frame: exactly one upd_ack; all digits show 8'hA4.
- wr_en of 16'h0005 on the exact boundary cycle: upd_ack is in the same cycle, pending never rises, and the next frame shows "5" on digit 0.
- Leading-zero blanking, lz_en=1, value 16'h0050:
  - an_n never low for digits 3 and 2; digits 1 and 0 light with 8'h92 and 8'hC0;
  - with wr_dp=4'b0100, digit 2 lights as 8'h40.
- rst asserted mid-slot with pending=1: outputs go to F/FF asynchronously, no upd_ack, pending=0, and the display resumes showing 0000.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scan controller.
// Segment bit positions match the seg_n bus: 7=dp, 6=g ... 0=a.
package seg7_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;
  localparam logic [7:0]            SEG_OFF   = 8'hFF;

  // One complete display image: four hex nibbles plus their decimal points.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
  } disp_data_t;

  // Builds an active-high segment byte from individual segment enables.
  function automatic logic [7:0] seg_pattern(input logic a, input logic b, input logic c,
                                             input logic d, input logic e, input logic f,
                                             input logic g);
    logic [7:0] p;
    p         = '0;
    p[SEG_A]  = a;
    p[SEG_B]  = b;
    p[SEG_C]  = c;
    p[SEG_D]  = d;
    p[SEG_E]  = e;
    p[SEG_F]  = f;
    p[SEG_G]  = g;
    p[SEG_DP] = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Data/handshake and display-side signals of the scan controller.
// master = the host driving writes, slave = the scan controller.
interface seg7_scan_ctrl_if;
  import seg7_scan_ctrl_pkg::*;

  logic                  wr_en;
  logic [15:0]           wr_data;
  logic [NUM_DIGITS-1:0] wr_dp;
  logic                  lz_en;
  logic                  upd_ack;
  logic                  pending;
  logic [NUM_DIGITS-1:0] an_n;
  logic [7:0]            seg_n;

  modport master (
    output wr_en, wr_data, wr_dp, lz_en,
    input  upd_ack, pending, an_n, seg_n
  );

  modport slave (
    input  wr_en, wr_data, wr_dp, lz_en,
    output upd_ack, pending, an_n, seg_n
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex7seg.sv
// Combinational hex-to-7-segment decoder (active-high segments, bit 7 always 0).
// One instance is shared by all digits of the scan controller.
module hex7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] code
);

  always_comb begin
    code = '0;
    case (value)
      //                     a     b     c     d     e     f     g
      4'h0: code = seg_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      4'h1: code = seg_pattern(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      4'h2: code = seg_pattern(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      4'h3: code = seg_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      4'h4: code = seg_pattern(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      4'h5: code = seg_pattern(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      4'h6: code = seg_pattern(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      4'h7: code = seg_pattern(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      4'h8: code = seg_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      4'h9: code = seg_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      4'hA: code = seg_pattern(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      4'hB: code = seg_pattern(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      4'hC: code = seg_pattern(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      4'hD: code = seg_pattern(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      4'hE: code = seg_pattern(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      default: code = seg_pattern(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment scan controller with a blank gap
// per slot, leading-zero blanking and tear-free data commit at frame boundaries.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] BLANK_LIM  = 16'(BLANK_CYC);

  logic [15:0]           presc_reg,     presc_next;
  logic [1:0]            digit_sel_reg, digit_sel_next;
  disp_data_t            shadow_reg,    shadow_next;
  disp_data_t            pend_reg,      pend_next;
  logic                  pending_reg,   pending_next;
  logic                  upd_ack_reg,   upd_ack_next;
  logic [NUM_DIGITS-1:0] an_n_reg,      an_n_next;
  logic [7:0]            seg_n_reg,     seg_n_next;

  logic                  slot_tick;
  logic                  frame_bnd;
  logic [3:0]            nibble;
  logic [7:0]            dec_code;
  logic [NUM_DIGITS-1:0] digit_blank;
  disp_data_t            wr_image;

  assign slot_tick = (presc_reg == PRESC_LAST);
  assign frame_bnd = slot_tick && (digit_sel_reg == 2'd3);
  assign wr_image  = '{value: bus.wr_data, dp: bus.wr_dp};

  // A digit is blank when it and every more-significant nibble are zero and
  // it carries no decimal point; the rightmost digit always shows.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign digit_blank[gi] = 1'b0;
      end else begin : g_upper
        assign digit_blank[gi] = bus.lz_en
                               && (shadow_reg.value[4*NUM_DIGITS-1:4*gi] == '0)
                               && !shadow_reg.dp[gi];
      end
    end
  endgenerate

  assign nibble = shadow_reg.value[{digit_sel_reg, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .value (nibble),
    .code  (dec_code)
  );

  // Prescaler and digit scan.
  always_comb begin
    presc_next     = presc_reg + 16'd1;
    digit_sel_next = digit_sel_reg;
    if (slot_tick) begin
      presc_next     = '0;
      digit_sel_next = digit_sel_reg + 2'd1;
    end
  end

  // Write handshake: a write on the boundary cycle bypasses the pending stage.
  always_comb begin
    shadow_next  = shadow_reg;
    pend_next    = pend_reg;
    pending_next = pending_reg;
    upd_ack_next = 1'b0;
    if (frame_bnd) begin
      if (bus.wr_en) begin
        shadow_next  = wr_image;
        pending_next = 1'b0;
        upd_ack_next = 1'b1;
      end else if (pending_reg) begin
        shadow_next  = pend_reg;
        pending_next = 1'b0;
        upd_ack_next = 1'b1;
      end
    end else if (bus.wr_en) begin
      pend_next    = wr_image;
      pending_next = 1'b1;
    end
  end

  // Display outputs are computed from the current scan position and registered.
  always_comb begin
    an_n_next  = ANODE_OFF;
    seg_n_next = ~{shadow_reg.dp[digit_sel_reg], dec_code[SEG_G:SEG_A]};
    if ((presc_reg >= BLANK_LIM) && !digit_blank[digit_sel_reg]) begin
      an_n_next[digit_sel_reg] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg     <= '0;
      digit_sel_reg <= '0;
      shadow_reg    <= '0;
      pend_reg      <= '0;
      pending_reg   <= 1'b0;
      upd_ack_reg   <= 1'b0;
      an_n_reg      <= ANODE_OFF;
      seg_n_reg     <= SEG_OFF;
    end else begin
      presc_reg     <= presc_next;
      digit_sel_reg <= digit_sel_next;
      shadow_reg    <= shadow_next;
      pend_reg      <= pend_next;
      pending_reg   <= pending_next;
      upd_ack_reg   <= upd_ack_next;
      an_n_reg      <= an_n_next;
      seg_n_reg     <= seg_n_next;
    end
  end

  assign bus.an_n    = an_n_reg;
  assign bus.seg_n   = seg_n_reg;
  assign bus.pending = pending_reg;
  assign bus.upd_ack = upd_ack_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-level reference model queues the
// expected outputs for every clock, and a negedge monitor compares them.
module tb_seg7_scan_ctrl;

  localparam int D     = 4;
  localparam int B     = 1;
  localparam int FRAME = 4 * D;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ack;
    logic       pend;
  } exp_t;

  logic clk;
  logic rst;
  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.CLK_DIV(D), .BLANK_CYC(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_seen = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, want);
  endtask

  // Active-high segment patterns of the hex digits 0..F (g..a).
  function automatic logic [6:0] font(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Reference model: position in the scan follows from the cycle count since reset.
  int          m_cyc  = 0;
  logic [15:0] m_val  = '0;
  logic [3:0]  m_dp   = '0;
  logic [15:0] m_pval = '0;
  logic [3:0]  m_pdp  = '0;
  logic        m_pend = 1'b0;

  always @(posedge clk) begin
    exp_t       e;
    int         phase, digit;
    bit         boundary, lit;
    logic [3:0] one;
    if (rst) begin
      m_cyc = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pend = 1'b0;
      e.an = 4'hF; e.seg = 8'hFF; e.ack = 1'b0; e.pend = 1'b0;
    end else begin
      phase    = m_cyc % D;
      digit    = (m_cyc / D) % 4;
      boundary = (phase == D - 1) && (digit == 3);
      lit      = (phase >= B);
      if (bus.lz_en && digit != 0 && (m_val >> (4 * digit)) == 0 && !m_dp[digit]) lit = 0;
      one   = 4'b0001;
      e.an  = lit ? ~(one << digit) : 4'hF;
      e.seg = ~{m_dp[digit], font(int'((m_val >> (4 * digit)) & 16'hF))};
      e.ack = boundary && (m_pend || bus.wr_en);
      if (boundary) begin
        if (bus.wr_en) begin m_val = bus.wr_data; m_dp = bus.wr_dp; end
        else if (m_pend) begin m_val = m_pval; m_dp = m_pdp; end
        m_pend = 1'b0;
      end else if (bus.wr_en) begin
        m_pval = bus.wr_data; m_pdp = bus.wr_dp; m_pend = 1'b1;
      end
      e.pend = m_pend;
      m_cyc++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an_n",    32'(bus.an_n),    32'(e.an));
      chk("seg_n",   32'(bus.seg_n),   32'(e.seg));
      chk("upd_ack", 32'(bus.upd_ack), 32'(e.ack));
      chk("pending", 32'(bus.pending), 32'(e.pend));
      if (bus.upd_ack) begin
        ack_seen++;
        $display("ack   t=%0t shown=%h", $time, bus.an_n);
      end
    end
  end

  // All stimulus tasks are entered and left just after a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp);
    $display("write t=%0t data=%h dp=%b lz=%b", $time, d, dp, bus.lz_en);
    bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_dp = dp;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Advance until the coming rising edge is at frame position pos.
  task automatic seek(input int pos);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      if (m_cyc % FRAME == pos) return;
      @(negedge clk);
    end
    chk("seek_timeout", 32'(m_cyc % FRAME), 32'(pos));
  endtask

  initial begin
    int a0;
    logic [15:0] d;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_dp = '0; bus.lz_en = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(2 * FRAME + 3);

    // Mid-frame write waits for the frame boundary.
    seek(5);
    write(16'h12AF, 4'b0010);
    chk("pending_after_write", 32'(bus.pending), 32'd1);
    cycles(2 * FRAME);

    // Two writes in one frame: only the last is committed and acked.
    seek(1);
    a0 = ack_seen;
    write(16'h1111, 4'b0000);
    cycles(3);
    write(16'h2222, 4'b0000);
    cycles(2 * FRAME);
    chk("single_ack", 32'(ack_seen - a0), 32'd1);

    // Write exactly on the boundary cycle.
    seek(FRAME - 1);
    write(16'h0005, 4'b0000);
    chk("bnd_ack", 32'(bus.upd_ack), 32'd1);
    chk("bnd_pending", 32'(bus.pending), 32'd0);
    cycles(2 * FRAME);

    // Leading-zero blanking.
    bus.lz_en = 1'b1;
    write(16'h0050, 4'b0000);
    cycles(2 * FRAME + 2);
    write(16'h0050, 4'b0100);
    cycles(2 * FRAME + 2);

    // Randomised writes, data biased toward leading zeros, lz_en toggled.
    for (int i = 0; i < 40; i++) begin
      bus.lz_en = 1'($urandom_range(0, 1));
      cycles($urandom_range(0, 20));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 3));
      write(d, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
    end
    cycles(2 * FRAME);

    // Asynchronous reset between edges with a write pending.
    bus.lz_en = 1'b0;
    seek(5);
    write(16'hBEEF, 4'b1111);
    chk("pending_before_rst", 32'(bus.pending), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_an_n",    32'(bus.an_n),    32'h0000000F);
    chk("rst_seg_n",   32'(bus.seg_n),   32'h000000FF);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_upd_ack", 32'(bus.upd_ack), 32'd0);
    a0 = ack_seen;
    cycles(2);
    rst = 1'b0;
    cycles(3 * FRAME);
    chk("no_ack_after_rst", 32'(ack_seen - a0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
